// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared constants for the bit-serial subtractor.
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - cnt_width(): width of the bit counter for a given operand width
// No ports; imported by serial_subtractor.
package serial_sub_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // $clog2(width) bits count 0..width-1. Floor at 1 so a counter always exists.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: single-bit combinational full subtractor, a - b - bin.
// Ports:
//   a, b, bin  : minuend bit, subtrahend bit, borrow in
//   diff, bout : difference bit, borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a, or when the bits match and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, A - B, LSB first, one
// bit per clock through a single full_subtractor cell and a borrow flop.
// Operands in and result out over valid/ready handshakes.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// SHIFT | busy=1, one result bit per cycle, WIDTH cycles
// DONE  | out_valid=1, result held until out_ready
//
// Ports:
//   clk, rst              : clock (rising edge), async active-high reset
//   in_valid, in_ready    : operand handshake, a/b sampled on accept edge
//   a, b                  : minuend, subtrahend (WIDTH bits)
//   out_valid, out_ready  : result handshake
//   diff, borrow_out      : A - B mod 2^WIDTH, borrow out of the MSB
//   busy                  : high while in SHIFT
//
// Build option: define SERIAL_SUBTRACTOR_SATURATE_EN to clamp diff to 0
// whenever borrow_out=1 (saturating subtract). Timing is unchanged.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             bor;
  logic             borrow_r;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             bnext;

  full_subtractor u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (bor),
    .diff (d),
    .bout (bnext)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = {d, res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      bor      <= 1'b0;
      borrow_r <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa    <= a;
            sb    <= b;
            bor   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res <= res_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          bor <= bnext;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            borrow_r <= bnext;
            state    <= DONE;
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
            if (bnext) res <= '0;
`endif
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state == SHIFT);
  assign out_valid  = (state == DONE);
  assign diff       = res;
  assign borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;

  int passed = 0;
  int total  = 0;
  logic [W:0] sb_q[$];   // {borrow, diff}

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a_in),
    .b          (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic bw);
    logic [W-1:0] dd;
    dd = d;
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
    if (bw) dd = '0;
`endif
    sb_q.push_back({bw, dd});
  endtask

  // Output monitor: pops one expectation per result handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got %0h expected none", {borrow_out, diff});
      end else begin
        logic [W:0] e;
        e = sb_q.pop_front();
        check("result", {23'd0, borrow_out, diff}, {23'd0, e});
      end
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = av; b_in = bv;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(ed, eb);
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("valid_timeout", 0, 1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bw;
  } vec_t;

  vec_t vecs[$] = '{
    '{8'hFF, 8'h00, 8'hFF, 1'b0},
    '{8'h00, 8'h01, 8'hFF, 1'b1},
    '{8'h01, 8'h02, 8'hFF, 1'b1},
    '{8'h10, 8'h05, 8'h0B, 1'b0},
    '{8'h7F, 8'h80, 8'hFF, 1'b1},
    '{8'hAA, 8'h55, 8'h55, 1'b0},
    '{8'h55, 8'hAA, 8'hAB, 1'b1},
    '{8'hFF, 8'hFF, 8'h00, 1'b0},
    '{8'h3C, 8'h0F, 8'h2D, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit got;
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
    #12;
    check("reset_state", {27'd0, in_ready, out_valid, busy, borrow_out, 1'b0} | {24'd0, diff},
          {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 rst = 1'b0;

    // Basic subtract and latency from accept to out_valid.
    issue(8'h5A, 8'h23, 8'h37, 1'b0);
    wait_valid(lat);
    check("latency", lat, 9);
    @(negedge clk);
    check("idle_after_done", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});

    // Underflow boundary.
    issue(8'h00, 8'hFF, 8'h01, 1'b1);
    wait_valid(lat);

    // Backpressure: result held stable while out_ready is low.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(8'h80, 8'h01, 8'h7F, 1'b0);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      check("hold", {22'd0, out_valid, in_ready, borrow_out, diff},
            {22'd0, 1'b1, 1'b0, 1'b0, 8'h7F});
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});

    // Equal operands, a/b changed during SHIFT, second request held in_valid.
    @(posedge clk); #1;
    in_valid = 1'b1; a_in = 8'hC3; b_in = 8'hC3;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; push_exp(8'h00, 1'b0); break; end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    a_in = 8'h10; b_in = 8'h05;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
      check("in_ready_shift", {31'd0, in_ready}, 32'd0);
    end
    if (!got) check("valid_timeout", 0, 1);
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("second_accept", {31'd0, in_ready}, 32'd1);
    push_exp(8'h0B, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid(lat);

    // Directed table.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bw);
      wait_valid(lat);
    end

    // Random pairs with random out_ready (out_ready outside DONE is ignored).
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom); rb = W'($urandom);
      issue(ra, rb, ra - rb, (ra < rb));
      got = 0;
      for (int k = 0; k < 200; k++) begin
        @(posedge clk); #1 out_ready = 1'($urandom);
        @(negedge clk);
        if (out_valid && out_ready) begin got = 1; break; end
      end
      if (!got) check("rand_timeout", 0, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;

    // Asynchronous reset mid-operation.
    issue(8'h5A, 8'h23, 8'h37, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_mid", {24'd0, in_ready, out_valid, busy, borrow_out, 4'd0} | {24'd0, diff},
          {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    issue(8'hFF, 8'h01, 8'hFE, 1'b0);
    wait_valid(lat);
    check("latency_after_reset", lat, 9);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
